// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//   Handshaked data memory behind the data cache. A read returns a whole
//   aligned block of BLOCK_WORDS words. A write stores one word, and only the
//   bytes enabled by req_wstrb are written. Every request is answered after a
//   programmable number of wait cycles (LATENCY). Only one request is
//   outstanding at a time.
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN
//     When it is defined, a read that is not block-aligned or a write that is
//     not word-aligned is answered with resp_err=1 and resp_data=0, and such a
//     write is not committed. When it is undefined, resp_err is always 0 and
//     the address is silently aligned down.
//
// Ports
//   clk        in   1                    clock, rising edge
//   reset      in   1                    synchronous reset, active-high
//   req_valid  in   1                    request present
//   req_ready  out  1                    block can accept a request (IDLE only)
//   req_write  in   1                    1 = word write, 0 = block read
//   req_addr   in   ADDR_W               byte address (wraps modulo MEM_BYTES)
//   req_wdata  in   WORD_W               write word, little-endian
//   req_wstrb  in   WORD_W/8             byte enables for the write
//   resp_valid out  1                    response present
//   resp_ready in   1                    consumer takes the response
//   resp_data  out  BLOCK_WORDS*WORD_W   read block (byte 0 in [7:0]); 0 for writes
//   resp_err   out  1                    alignment error flag
// -----------------------------------------------------------------------------
module block_data_memory #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned WORD_W      = 64,
    parameter int unsigned BLOCK_WORDS = 2,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [WORD_W-1:0]             req_wdata,
    input  logic [WORD_W/8-1:0]           req_wstrb,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [BLOCK_WORDS*WORD_W-1:0] resp_data,
    output logic                          resp_err
);

    localparam int unsigned WB    = WORD_W / 8;
    localparam int unsigned BB    = BLOCK_WORDS * WB;
    localparam int unsigned BLK_W = BLOCK_WORDS * WORD_W;
    localparam int unsigned IDX_W = $clog2(MEM_BYTES);

    localparam logic [IDX_W-1:0] WORD_MASK = IDX_W'(WB - 1);
    localparam logic [IDX_W-1:0] BLK_MASK  = IDX_W'(BB - 1);
    // Terminal count of the wait counter; unused when LATENCY is 0.
    localparam logic [7:0]       LAT_LAST  = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [WB-1:0]      wstrb_q;
    logic [BLK_W-1:0]   resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;

    logic [7:0]         mem [MEM_BYTES];

    logic               accept;
    logic               enter_resp;
    logic               commit;

    // Only the low IDX_W address bits select storage; the rest wrap away.
    logic [IDX_W-1:0]   req_idx;
    assign req_idx = req_addr[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // With LATENCY=0 the response is produced on the accept edge itself, so
    // the operation is taken straight from the request inputs while in IDLE
    // and from the latched copy otherwise.
    logic               op_write;
    logic [IDX_W-1:0]   op_idx;
    logic [WORD_W-1:0]  op_wdata;
    logic [WB-1:0]      op_wstrb;

    always_comb begin
        if (state_q == IDLE) begin
            op_write = req_write;
            op_idx   = req_idx;
            op_wdata = req_wdata;
            op_wstrb = req_wstrb;
        end else begin
            op_write = wr_q;
            op_idx   = idx_q;
            op_wdata = wdata_q;
            op_wstrb = wstrb_q;
        end
    end

    // -------------------------------------------------------------------------
    // Address decode and alignment check
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] rd_base;
    logic [IDX_W-1:0] wr_base;
    logic             align_err;

    assign rd_base = op_idx & ~BLK_MASK;
    assign wr_base = op_idx & ~WORD_MASK;

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = op_write ? ((op_idx & WORD_MASK) != '0)
                                : ((op_idx & BLK_MASK) != '0);
`else
    assign align_err = 1'b0;
`endif

    // Aligned block read; the block never crosses the end of storage.
    logic [BLK_W-1:0] rd_block;

    always_comb begin
        rd_block = '0;
        for (int unsigned b = 0; b < BB; b++) begin
            rd_block[8*b +: 8] = mem[rd_base + IDX_W'(b)];
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_resp  = 1'b0;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response payload is captured once, on entry to RESP, and then held
        // until the consumer takes it.
        if (enter_resp) begin
            resp_err_d  = align_err;
            resp_data_d = (op_write || align_err) ? '0 : rd_block;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Request capture; contents are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // -------------------------------------------------------------------------
    // Storage (not cleared by reset). A reset before RESP entry drops the
    // pending write because commit is gated by reset.
    // -------------------------------------------------------------------------
    assign commit = enter_resp && op_write && !align_err && !reset;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < WB; b++) begin
                if (op_wstrb[b]) begin
                    mem[wr_base + IDX_W'(b)] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_block_data_memory.sv
// -----------------------------------------------------------------------------
// tb_block_data_memory
//   Directed, table-driven bench for block_data_memory with default sizing
//   (64-bit words, 2-word blocks, 1 KB storage, LATENCY=2). Table entries are
//   complete request/response transactions; multi-cycle corners (reset,
//   back-pressure, reset during WAIT, reset colliding with a request,
//   unaligned write) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_block_data_memory;

    localparam int unsigned LAT = 2;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [63:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [127:0]  resp_data;
    logic          resp_err;

    int n_vec;
    int n_err;

    block_data_memory #(
        .ADDR_W      (64),
        .WORD_W      (64),
        .BLOCK_WORDS (2),
        .MEM_BYTES   (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [63:0]  addr;
        logic [63:0]  wdata;
        logic [7:0]   wstrb;
        logic [127:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. After resp_valid rises, resp_ready is held low for
    // 'hold' cycles while stability is checked, then the response is taken.
    task automatic run_req(input string nm, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb,
                           input int hold, output logic [127:0] data,
                           output logic err, output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        chk({nm, "_ready"}, 128'(req_ready), 128'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 300) begin
            tick();
            lat++;
        end
        data = resp_data;
        err  = resp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({nm, "_hold_valid"}, 128'(resp_valid), 128'd1);
            chk({nm, "_hold_data"}, resp_data, data);
            chk({nm, "_hold_rdy"}, 128'(req_ready), 128'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic apply(input string nm, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb,
                         input int hold, input logic [127:0] exp_data,
                         input logic exp_err);
        logic [127:0] d;
        logic         e;
        int           l;
        run_req(nm, wr, addr, wdata, wstrb, hold, d, e, l);
        chk({nm, "_lat"}, 128'(l), 128'(LAT));
        chk({nm, "_data"}, d, exp_data);
        chk({nm, "_err"}, 128'(e), 128'(exp_err));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;

        //               wr    addr        wdata                   wstrb  exp_data                                   err
        vecs[0]  = '{1'b1, 64'h010, 64'h1122334455667788, 8'hFF, 128'h0,                                    1'b0};
        vecs[1]  = '{1'b1, 64'h018, 64'h0123456789ABCDEF, 8'hFF, 128'h0,                                    1'b0};
        vecs[2]  = '{1'b0, 64'h010, 64'h0,                8'h00, 128'h0123456789ABCDEF_1122334455667788, 1'b0};
        vecs[3]  = '{1'b1, 64'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 128'h0,                                    1'b0};
        vecs[4]  = '{1'b0, 64'h010, 64'h0,                8'h00, 128'h0123456789ABCDEF_11223344AAAAAAAA, 1'b0};
        vecs[5]  = '{1'b1, 64'h020, 64'hCAFEF00DDEADBEEF, 8'hFF, 128'h0,                                    1'b0};
        vecs[6]  = '{1'b1, 64'h028, 64'h5555666677778888, 8'hFF, 128'h0,                                    1'b0};
        vecs[7]  = '{1'b0, 64'h420, 64'h0,                8'h00, 128'h5555666677778888_CAFEF00DDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 64'h3F0, 64'h1111111111111111, 8'hFF, 128'h0,                                    1'b0};
        vecs[9]  = '{1'b1, 64'h3F8, 64'h2222222222222222, 8'hFF, 128'h0,                                    1'b0};
        vecs[10] = '{1'b1, 64'h7F8, 64'h99AABBCCDDEEFF00, 8'h81, 128'h0,                                    1'b0};
        vecs[11] = '{1'b0, 64'h3F0, 64'h0,                8'h00, 128'h9922222222222200_1111111111111111, 1'b0};

        // Reset held for three cycles.
        tick();
        tick();
        tick();
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);
        chk("rst_resp_err", 128'(resp_err), 128'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 128'(req_ready), 128'd1);
        chk("post_rst_valid", 128'(resp_valid), 128'd0);

        // Table-driven transactions.
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].wstrb, 0, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Wrapped read of 0x410 under five cycles of back-pressure.
        apply("bp_read410", 1'b0, 64'h410, 64'h0, 8'h00, 5,
              128'h0123456789ABCDEF_11223344AAAAAAAA, 1'b0);

        // Reset during WAIT of a write to 0x20: dropped, no response.
        tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hDEADDEADDEADDEAD;
        req_wstrb = 8'hFF;
        tick();
        req_valid = 1'b0;
        chk("midwait_busy", 128'(req_ready), 128'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midwait_no_resp", 128'(resp_valid), 128'd0);
        end
        chk("midwait_idle", 128'(req_ready), 128'd1);

        // Reset together with req_valid: the request is not accepted.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h28;
        req_wdata = 64'hBADBADBADBADBAD0;
        req_wstrb = 8'hFF;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_req_no_resp", 128'(resp_valid), 128'd0);
        end

        apply("after_rst_read20", 1'b0, 64'h20, 64'h0, 8'h00, 0,
              128'h5555666677778888_CAFEF00DDEADBEEF, 1'b0);

        // Unaligned write to 0x23.
`ifdef DMEM_ALIGN_CHECK_EN
        apply("unal_wr23", 1'b1, 64'h23, 64'h7777777777777777, 8'hFF, 0, 128'h0, 1'b1);
        apply("unal_read20", 1'b0, 64'h20, 64'h0, 8'h00, 0,
              128'h5555666677778888_CAFEF00DDEADBEEF, 1'b0);
`else
        apply("unal_wr23", 1'b1, 64'h23, 64'h7777777777777777, 8'hFF, 0, 128'h0, 1'b0);
        apply("unal_read20", 1'b0, 64'h20, 64'h0, 8'h00, 0,
              128'h5555666677778888_7777777777777777, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
